cbp_adder_pipe: RTL and testbench

Pipelined, parametrised successor to the combinational carry-bypass adder. Operands are split into NUM_STAGES equal blocks. Each block is resolved in its own pipeline stage, with a bypass mux forwarding the incoming carry when every bit in the block propagates. The block adds a valid/ready handshake with per-stage backpressure, a signed/unsigned mode, and an overflow flag. It sits between operand sources and ALU result muxing, at a throughput of one add per cycle.

---
 rtl/cbp_pkg.sv | 20 ++
 rtl/cbp_adder_pipe_block.sv | 26 ++
 rtl/cbp_adder_pipe.sv | 93 +++++++++
 tb/tb_cbp_adder_pipe.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/cbp_pkg.sv
// Shared helpers and control record for the pipelined carry-bypass adder.
package cbp_pkg;

    function automatic int cbp_block_width(input int num_bits, input int num_stages);
        return num_bits / num_stages;
    endfunction

    // Legal split: whole blocks, each at least two bits wide.
    function automatic bit cbp_split_ok(input int num_bits, input int num_stages);
        return (num_stages > 0) && ((num_bits % num_stages) == 0) && ((num_bits / num_stages) >= 2);
    endfunction

    typedef struct packed {
        logic valid;
        logic carry;
        logic msb_cin;
        logic smode;
    } cbp_ctrl_t;

endpackage

// File: rtl/cbp_adder_pipe_block.sv
// One carry-bypass block: ripple add of W bits with the incoming carry
// forwarded straight to the carry out when every bit propagates.
module cbp_block #(
    parameter int W = 8
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         ci,
    output logic [W-1:0] s,
    output logic         co,
    output logic         msb_ci
);
    logic [W:0]   w_c;
    logic [W-1:0] w_p;

    assign w_p    = a ^ b;
    assign w_c[0] = ci;

    for (genvar gi = 0; gi < W; gi++) begin : g_ripple
        assign w_c[gi+1] = (a[gi] & b[gi]) | (w_p[gi] & w_c[gi]);
    end

    assign s      = w_p ^ w_c[W-1:0];
    assign co     = (&w_p) ? ci : w_c[W];
    assign msb_ci = w_c[W-1];
endmodule

// File: rtl/cbp_adder_pipe.sv
// Pipelined carry-bypass adder: one block per stage, bubble-collapsing
// valid/ready chain, signed/unsigned overflow taken from the last stage.
module cbp_adder_pipe
    import cbp_pkg::*;
#(
    parameter int NUM_BITS   = 32,
    parameter int NUM_STAGES = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [NUM_BITS-1:0] A,
    input  logic [NUM_BITS-1:0] B,
    input  logic                Cin,
    input  logic                signed_mode,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [NUM_BITS-1:0] Sum,
    output logic                Cout,
    output logic                Ovf
);
    localparam int W = cbp_block_width(NUM_BITS, NUM_STAGES);

    if (!cbp_split_ok(NUM_BITS, NUM_STAGES)) begin : g_bad_split
        $error("cbp_adder_pipe: NUM_BITS must split into NUM_STAGES blocks of >= 2 bits");
    end

    typedef struct packed {
        logic [NUM_BITS-1:0] a_rem;
        logic [NUM_BITS-1:0] b_rem;
        logic [NUM_BITS-1:0] sum_acc;
        cbp_ctrl_t           ctrl;
    } stage_t;

    stage_t                  w_src   [NUM_STAGES];
    stage_t                  w_stage [NUM_STAGES];
    logic                    w_adv   [NUM_STAGES];
    logic [NUM_STAGES-1:0]   w_vld;

    assign w_src[0] = '{a_rem: A, b_rem: B, sum_acc: '0,
                        ctrl: '{valid: in_valid & w_adv[0], carry: Cin,
                                msb_cin: 1'b0, smode: signed_mode}};

    for (genvar gi = 0; gi < NUM_STAGES; gi++) begin : g_stage
        logic [W-1:0] w_s;
        logic         w_co;
        logic         w_msb_ci;
        stage_t       w_next;
        stage_t       r_q;

        cbp_block #(.W(W)) u_block (
            .a      (w_src[gi].a_rem[gi*W +: W]),
            .b      (w_src[gi].b_rem[gi*W +: W]),
            .ci     (w_src[gi].ctrl.carry),
            .s      (w_s),
            .co     (w_co),
            .msb_ci (w_msb_ci)
        );

        always_comb begin
            w_next                    = w_src[gi];
            w_next.sum_acc[gi*W +: W] = w_s;
            w_next.ctrl.carry         = w_co;
            w_next.ctrl.msb_cin       = w_msb_ci;
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_q <= '0;
            end else if (w_adv[gi]) begin
                r_q <= w_next;
            end
        end

        assign w_stage[gi] = r_q;
        assign w_vld[gi]   = r_q.ctrl.valid;
        // A stage may move if any stage at or after it holds a bubble, or the sink pops.
        assign w_adv[gi]   = out_ready | ~(&w_vld[NUM_STAGES-1:gi]);

        if (gi > 0) begin : g_link
            assign w_src[gi] = w_stage[gi-1];
        end
    end

    assign in_ready  = w_adv[0];
    assign out_valid = w_stage[NUM_STAGES-1].ctrl.valid;
    assign Sum       = w_stage[NUM_STAGES-1].sum_acc;
    assign Cout      = w_stage[NUM_STAGES-1].ctrl.carry;
    assign Ovf       = w_stage[NUM_STAGES-1].ctrl.smode
                     ? (w_stage[NUM_STAGES-1].ctrl.msb_cin ^ w_stage[NUM_STAGES-1].ctrl.carry)
                     : w_stage[NUM_STAGES-1].ctrl.carry;
endmodule

// File: tb/tb_cbp_adder_pipe.sv
// Randomised and directed bench for cbp_adder_pipe against an arithmetic
// model held in a FIFO scoreboard.
module tb_cbp_adder_pipe;
    localparam int NB = 32;
    localparam int NS = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [NB-1:0] A = '0;
    logic [NB-1:0] B = '0;
    logic          Cin = 1'b0;
    logic          signed_mode = 1'b0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [NB-1:0] Sum;
    logic          Cout;
    logic          Ovf;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int or_mode = 0;
    int stall_base = 0;

    typedef struct {
        logic [NB-1:0] sum;
        logic          cout;
        logic          ovf;
        bit            has_lit;
        logic [NB-1:0] lsum;
        logic          lcout;
        logic          lovf;
        bit            chk_lat;
        int            acc_edge;
    } exp_t;

    exp_t q[$];

    bit            drv_has_lit = 0;
    bit            drv_chk_lat = 0;
    logic [NB-1:0] drv_lsum = '0;
    logic          drv_lcout = 1'b0;
    logic          drv_lovf = 1'b0;

    bit            held_valid = 0;
    logic [NB-1:0] held_sum;
    logic          held_cout;
    logic          held_ovf;
    bit            saw_full = 0;

    cbp_adder_pipe #(.NUM_BITS(NB), .NUM_STAGES(NS)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .A(A), .B(B), .Cin(Cin), .signed_mode(signed_mode),
        .out_valid(out_valid), .out_ready(out_ready),
        .Sum(Sum), .Cout(Cout), .Ovf(Ovf)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [NB-1:0] act, input logic [NB-1:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    function automatic exp_t model(input logic [NB-1:0] a, input logic [NB-1:0] b,
                                   input logic cin, input logic sm);
        exp_t e;
        logic [NB:0] t;
        t = {1'b0, a} + {1'b0, b} + {{NB{1'b0}}, cin};
        e.sum  = t[NB-1:0];
        e.cout = t[NB];
        e.ovf  = sm ? ((a[NB-1] == b[NB-1]) && (e.sum[NB-1] != a[NB-1])) : e.cout;
        e.has_lit = 0; e.lsum = '0; e.lcout = 1'b0; e.lovf = 1'b0;
        e.chk_lat = 0; e.acc_edge = 0;
        return e;
    endfunction

    // Sink-side readiness pattern, updated just after each rising edge.
    always @(posedge clk) begin
        #1;
        case (or_mode)
            0:       out_ready = 1'b1;
            1:       out_ready = ($urandom_range(0, 3) != 0);
            2:       out_ready = !(((cyc - stall_base) >= 3) && ((cyc - stall_base) <= 6));
            default: out_ready = 1'b0;
        endcase
    end

    // Scoreboard: pop on output handshake, push on input handshake.
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            held_valid = 0;
        end else begin
            check("in_ready", NB'(in_ready), NB'((q.size() < NS) || out_ready));
            if (!in_ready) saw_full = 1;
            if (held_valid) begin
                check("stall_valid", NB'(out_valid), NB'(1));
                check("stall_sum", Sum, held_sum);
                check("stall_cout", NB'(Cout), NB'(held_cout));
                check("stall_ovf", NB'(Ovf), NB'(held_ovf));
            end
            if (out_valid && q.size() == 0) begin
                check("no_stale_out", NB'(out_valid), NB'(0));
            end else if (out_valid && out_ready) begin
                e = q.pop_front();
                check("sum", Sum, e.sum);
                check("cout", NB'(Cout), NB'(e.cout));
                check("ovf", NB'(Ovf), NB'(e.ovf));
                if (e.has_lit) begin
                    check("lit_sum", Sum, e.lsum);
                    check("lit_cout", NB'(Cout), NB'(e.lcout));
                    check("lit_ovf", NB'(Ovf), NB'(e.lovf));
                end
                if (e.chk_lat) check("latency", NB'(cyc - e.acc_edge), NB'(NS - 1));
            end
            held_valid = out_valid && !out_ready;
            held_sum = Sum; held_cout = Cout; held_ovf = Ovf;
            if (in_valid && in_ready) begin
                e = model(A, B, Cin, signed_mode);
                e.has_lit = drv_has_lit; e.lsum = drv_lsum;
                e.lcout = drv_lcout; e.lovf = drv_lovf;
                e.chk_lat = drv_chk_lat; e.acc_edge = cyc + 1;
                if (drv_has_lit) begin
                    check("model_sum", e.sum, drv_lsum);
                    check("model_cout", NB'(e.cout), NB'(drv_lcout));
                    check("model_ovf", NB'(e.ovf), NB'(drv_lovf));
                end
                q.push_back(e);
            end
        end
    end

    task automatic send(input logic [NB-1:0] a, input logic [NB-1:0] b, input logic cin,
                        input logic sm, input bit lit, input logic [NB-1:0] ls,
                        input logic lc, input logic lo, input bit lat);
        bit acc = 0;
        A = a; B = b; Cin = cin; signed_mode = sm;
        drv_has_lit = lit; drv_lsum = ls; drv_lcout = lc; drv_lovf = lo; drv_chk_lat = lat;
        in_valid = 1'b1;
        for (int n = 0; n < 300 && !acc; n++) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        drv_has_lit = 0; drv_chk_lat = 0;
        if (!acc) begin
            checks++; errors++;
            $display("FAIL send_accept: in_ready got 0 for 300 cycles, required 1");
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drain();
        int n = 0;
        while (q.size() != 0 && n < 1000) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (q.size() != 0) begin
            checks++; errors++;
            $display("FAIL drain: %0d results outstanding, required 0", q.size());
        end
    endtask

    initial begin
        logic [NB-1:0] ra;
        logic [NB-1:0] rb;
        int kind;
        #1 rst = 1'b1;
        #1;
        check("rst_out_valid", NB'(out_valid), NB'(0));
        check("rst_sum", Sum, '0);
        check("rst_cout", NB'(Cout), NB'(0));
        check("rst_ovf", NB'(Ovf), NB'(0));
        repeat (2) @(posedge clk);
        #3 rst = 1'b0;
        #1 check("in_ready_after_rst", NB'(in_ready), NB'(1));
        @(posedge clk);
        #1;
        or_mode = 0; out_ready = 1'b1;
        idle(2);

        // Directed vectors with hand-computed results.
        send(32'd10, 32'd20, 1'b0, 1'b0, 1, 32'd30, 1'b0, 1'b0, 1);
        send(32'd10, 32'd20, 1'b1, 1'b0, 1, 32'd31, 1'b0, 1'b0, 0);
        send(32'hFFFF_FFF6, 32'hFFFF_FFEC, 1'b0, 1'b1, 1, 32'hFFFF_FFE2, 1'b1, 1'b0, 0);
        send(32'hFFFF_FFF6, 32'hFFFF_FFEC, 1'b0, 1'b0, 1, 32'hFFFF_FFE2, 1'b1, 1'b1, 0);
        send(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b1, 1, 32'h8000_0000, 1'b0, 1'b1, 0);
        send(32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b1, 1, 32'h0000_0000, 1'b1, 1'b0, 0);
        send(32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0, 1, 32'h0000_0000, 1'b1, 1'b1, 0);
        drain();

        // Back-to-back stream with a four-cycle sink stall.
        saw_full = 0;
        stall_base = cyc;
        or_mode = 2;
        for (int i = 0; i < 8; i++) begin
            send(NB'(i), NB'(100 * i), logic'(i % 2), 1'b0, 1,
                 NB'(101 * i + (i % 2)), 1'b0, 1'b0, 0);
        end
        drain();
        check("stream_saw_full", NB'(saw_full), NB'(1));
        or_mode = 0;
        idle(2);

        // Random traffic with random sink backpressure.
        or_mode = 1;
        for (int i = 0; i < 200; i++) begin
            kind = $urandom_range(0, 3);
            ra = $urandom;
            rb = $urandom;
            if (kind == 1) rb = ~ra;
            if (kind == 2) begin ra = {1'b0, {(NB-1){1'b1}}}; rb = $urandom_range(0, 2); end
            send(ra, rb, logic'($urandom_range(0, 1)), logic'($urandom_range(0, 1)),
                 0, '0, 1'b0, 1'b0, 0);
            idle($urandom_range(0, 2));
        end
        drain();

        // Reset with beats in flight.
        or_mode = 3; out_ready = 1'b0;
        idle(1);
        for (int i = 0; i < 3; i++) begin
            send($urandom, $urandom, 1'b0, 1'b0, 0, '0, 1'b0, 1'b0, 0);
        end
        #2 rst = 1'b1;
        #1;
        q.delete();
        check("midrst_out_valid", NB'(out_valid), NB'(0));
        check("midrst_sum", Sum, '0);
        check("midrst_cout", NB'(Cout), NB'(0));
        check("midrst_ovf", NB'(Ovf), NB'(0));
        @(posedge clk);
        #3 rst = 1'b0;
        or_mode = 0; out_ready = 1'b1;
        #1 check("in_ready_after_midrst", NB'(in_ready), NB'(1));
        @(posedge clk);
        #1;
        idle(10);
        send(32'd5, 32'd6, 1'b0, 1'b0, 1, 32'd11, 1'b0, 1'b0, 0);
        send(32'h8000_0000, 32'h8000_0000, 1'b0, 1'b1, 1, 32'd0, 1'b1, 1'b1, 0);
        drain();
        idle(3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation still running at %0t, required finish", $time);
        $fatal(1, "timeout");
    end
endmodule
